serial_sub: RTL and testbench

- Bit-serial two's-complement subtractor computing A - B, LSB first, one bit per accepted cycle.
- Counterpart to the combinational ripple adder cell: shares its per-bit datapath but runs one cell in time with a registered borrow instead of a chain of carry cells.
- Used by block-level benches and serial datapaths that stream operands bit by bit.

---
 rtl/serial_sub_if.sv | 38 +++
 rtl/serial_sub.sv | 114 +++++++++++
 tb/tb_serial_sub.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_if.sv
// Handshake bundle for the bit-serial subtractor: operand bit stream in, difference bit stream out.
// op_add exists only when SERIAL_SUB_ADD_MODE_EN is defined.
interface serial_sub_if;
    logic start;
    logic in_valid;
    logic a_bit;
    logic b_bit;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic op_add;
`endif
    logic busy;
    logic out_valid;
    logic diff_bit;
    logic last;
    logic done;
    logic borrow_out;
    logic overflow;

`ifdef SERIAL_SUB_ADD_MODE_EN
    modport master (
        output start, in_valid, a_bit, b_bit, op_add,
        input  busy, out_valid, diff_bit, last, done, borrow_out, overflow
    );
    modport slave (
        input  start, in_valid, a_bit, b_bit, op_add,
        output busy, out_valid, diff_bit, last, done, borrow_out, overflow
    );
`else
    modport master (
        output start, in_valid, a_bit, b_bit,
        input  busy, out_valid, diff_bit, last, done, borrow_out, overflow
    );
    modport slave (
        input  start, in_valid, a_bit, b_bit,
        output busy, out_valid, diff_bit, last, done, borrow_out, overflow
    );
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial two's-complement A - B, LSB first, one ripple cell reused in time with a registered borrow.
// Define SERIAL_SUB_ADD_MODE_EN to add an op_add input selecting serial addition per frame.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic            br;
    logic            add_mode;
    logic            accept, is_last;
    logic            d_nx, br_nx, ovf_nx;
    logic            vld_p1, diff_p1, last_p1, done_p1;
    logic            borrow_q, ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // start always wins over a bit in the same cycle, including the final bit
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        is_last  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nx = RUN;
            end
            RUN: begin
                if (bus.start) begin
                    state_nx = RUN;
                end else if (bus.in_valid) begin
                    accept = 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        is_last  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef SERIAL_SUB_ADD_MODE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         add_mode <= 1'b0;
        else if (bus.start) add_mode <= bus.op_add;
    end
`else
    assign add_mode = 1'b0;
`endif

    // One full-subtractor / full-adder cell; br holds borrow (or carry in add mode)
    always_comb begin
        d_nx = bus.a_bit ^ bus.b_bit ^ br;
        if (add_mode) begin
            br_nx  = (bus.a_bit & bus.b_bit) | (br & (bus.a_bit ^ bus.b_bit));
            ovf_nx = (bus.a_bit == bus.b_bit) & (d_nx != bus.a_bit);
        end else begin
            br_nx  = (~bus.a_bit & bus.b_bit) | (~(bus.a_bit ^ bus.b_bit) & br);
            ovf_nx = (bus.a_bit != bus.b_bit) & (d_nx != bus.a_bit);
        end
    end

    // Stage p1: registered result bit, framing flags and frame status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br       <= 1'b0;
            cnt      <= '0;
            vld_p1   <= 1'b0;
            diff_p1  <= 1'b0;
            last_p1  <= 1'b0;
            done_p1  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            vld_p1  <= accept;
            last_p1 <= is_last;
            done_p1 <= is_last;
            if (bus.start) begin
                br       <= 1'b0;
                cnt      <= '0;
                borrow_q <= 1'b0;
                ovf_q    <= 1'b0;
            end else if (accept) begin
                diff_p1 <= d_nx;
                br      <= br_nx;
                cnt     <= is_last ? '0 : cnt + 1'b1;
                if (is_last) begin
                    borrow_q <= br_nx;
                    ovf_q    <= ovf_nx;
                end
            end
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.out_valid  = vld_p1;
    assign bus.diff_bit   = diff_p1;
    assign bus.last       = last_p1;
    assign bus.done       = done_p1;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: vector table, hand-written stall/reset/restart sequences and random frames
// checked against an arithmetic reference model.
module tb_serial_sub;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_sub_if bus();
    serial_sub #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         add;
        logic [7:0] exp_r;
        bit         exp_bo;
        bit         exp_ov;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int stall_len [8];
    bit op_mode = 1'b0;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.busy, bus.out_valid, bus.diff_bit, bus.last, bus.done, bus.borrow_out, bus.overflow};
    endfunction

    // Reference: whole-word arithmetic on the operands
    task automatic model(input logic [7:0] a, input logic [7:0] b, input bit add,
                         output logic [7:0] r, output bit bo, output bit ov);
        int ua, ub, sa, sb, u, s;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        if (add) begin
            u = ua + ub; s = sa + sb;
            bo = (u > 255);
        end else begin
            u = ua - ub; s = sa - sb;
            bo = (ua < ub);
        end
        r  = u[7:0];
        ov = (s > 127) || (s < -128);
    endtask

    task automatic feed_bit(input logic a, input logic b);
        bus.in_valid = 1'b1; bus.a_bit = a; bus.b_bit = b;
        step();
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             output logic [7:0] r, output bit bo, output bit ov, output bit tim_ok);
        tim_ok = 1'b1; r = '0; bo = 1'b0; ov = 1'b0;
        bus.start = 1'b1; bus.in_valid = 1'b1;
`ifdef SERIAL_SUB_ADD_MODE_EN
        bus.op_add = op_mode;
`endif
        step();
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.borrow_out !== 1'b0) tim_ok = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            feed_bit(a[i], b[i]);
            if (bus.out_valid !== 1'b1 || bus.last !== (i == 7) || bus.done !== (i == 7)) tim_ok = 1'b0;
            r[i] = bus.diff_bit;
            if (i == 7) begin
                bo = bus.borrow_out; ov = bus.overflow;
                if (bus.busy !== 1'b0) tim_ok = 1'b0;
            end else begin
                if (bus.busy !== 1'b1) tim_ok = 1'b0;
                for (int s = 0; s < stall_len[i]; s++) begin
                    bus.in_valid = 1'b0; bus.a_bit = 1'($urandom); bus.b_bit = 1'($urandom);
                    step();
                    if (bus.out_valid !== 1'b0) tim_ok = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        step();
        if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.borrow_out !== bo || bus.overflow !== ov)
            tim_ok = 1'b0;
    endtask

    task automatic do_frame(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] er, input bit ebo, input bit eov);
        logic [7:0] r; bit bo, ov, t;
        run_frame(a, b, r, bo, ov, t);
        chk({nm, "_result"}, r, er);
        chk({nm, "_borrow"}, bo, ebo);
        chk({nm, "_overflow"}, ov, eov);
        chk({nm, "_timing"}, t, 1'b1);
    endtask

    initial begin
        vec_t tbl [$];
        int d0;
        logic [7:0] mr; bit mbo, mov;

        tbl.push_back('{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0});
        tbl.push_back('{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0});
        tbl.push_back('{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1});
        tbl.push_back('{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1});
        tbl.push_back('{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0});
        tbl.push_back('{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
`ifdef SERIAL_SUB_ADD_MODE_EN
        tbl.push_back('{8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1});
        tbl.push_back('{8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1});
`endif

        bus.start = 1'b0; bus.in_valid = 1'b0; bus.a_bit = 1'b0; bus.b_bit = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
        bus.op_add = 1'b0;
`endif
        foreach (stall_len[i]) stall_len[i] = 0;

        #1;
        chk("reset_outputs", outs(), 7'b0);
        // in_valid while idle must not start anything
        bus.in_valid = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("idle_ignores_in_valid", {bus.busy, bus.out_valid}, 2'b00);
        bus.in_valid = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            op_mode = tbl[k].add;
            do_frame($sformatf("vec%0d", k), tbl[k].a, tbl[k].b, tbl[k].exp_r, tbl[k].exp_bo, tbl[k].exp_ov);
        end
        op_mode = 1'b0;

        stall_len[2] = 3; stall_len[5] = 1;
        do_frame("stall", 8'h55, 8'h0F, 8'h46, 1'b0, 1'b0);
        foreach (stall_len[i]) stall_len[i] = 0;

        // asynchronous reset in the middle of a frame
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int i = 0; i < 4; i++) feed_bit(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", outs(), 7'b0);
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        do_frame("after_reset", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // restart after 5 bits: only the second frame may complete
        d0 = done_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int i = 0; i < 5; i++) feed_bit(1'((8'h10 >> i) & 1), 1'((8'h20 >> i) & 1));
        do_frame("restart", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        chk("restart_done_pulses", done_cnt - d0, 1);

        // start coinciding with the final bit aborts that frame
        d0 = done_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int i = 0; i < 7; i++) feed_bit(1'b0, 1'b1);
        bus.start = 1'b1;
        feed_bit(1'b0, 1'b1);
        chk("start_on_last_flags", {bus.out_valid, bus.done, bus.busy}, 3'b001);
        bus.start = 1'b0; bus.in_valid = 1'b0;
        step();
        chk("start_on_last_no_done", done_cnt - d0, 0);
        do_frame("after_last_abort", 8'h20, 8'h10, 8'h10, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            logic [7:0] a, b;
            a = 8'($urandom); b = 8'($urandom);
`ifdef SERIAL_SUB_ADD_MODE_EN
            op_mode = 1'($urandom);
`else
            op_mode = 1'b0;
`endif
            foreach (stall_len[i]) stall_len[i] = $urandom_range(0, 2);
            model(a, b, op_mode, mr, mbo, mov);
            do_frame($sformatf("rand%0d", k), a, b, mr, mbo, mov);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
